// File: rtl/usb_tx_pkt_seq.sv
// USB transmit packet sequencer: steps SYNC, PID, payload, CRC and EOP bytes into an
// external bit shifter, pulling payload from a first-word-fall-through FIFO.
module usb_tx_pkt_seq #(
  parameter int MAX_LEN   = 64,
  parameter int LEN_W     = 7,
  parameter int CRC_BYTES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [7:0]       pid,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_read,
  input  logic [15:0]      crc_in,
  output logic             crc_clear,
  output logic             crc_update,
  output logic             shift_load,
  output logic [7:0]       shift_data,
  input  logic             byte_done,
  input  logic             tx_hold,
  output logic             create_eop,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             len_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_PID    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CRC_LO = 3'd4,
    ST_CRC_HI = 3'd5,
    ST_EOP    = 3'd6
  } state_e;

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);
  localparam bit               HAS_CRC   = (CRC_BYTES == 2);
  localparam state_e           POST_DATA = HAS_CRC ? ST_CRC_LO : ST_EOP;

  state_e           state_q;
  logic             loaded_q;
  logic [LEN_W-1:0] remaining_q;
  logic [LEN_W-1:0] len_q;
  logic [7:0]       pid_q;

  logic start_ok_s;
  logic len_bad_s;
  logic byte_state_s;
  logic load_cycle_s;

  assign start_ok_s   = (state_q == ST_IDLE) && start && (length <= MAX_LEN_C);
  assign len_bad_s    = (state_q == ST_IDLE) && start && (length > MAX_LEN_C);
  assign byte_state_s = (state_q == ST_SYNC) || (state_q == ST_PID) || (state_q == ST_DATA) ||
                        (state_q == ST_CRC_LO) || (state_q == ST_CRC_HI);
  // An abort cancels the load so no FIFO byte is popped for a packet being dropped.
  assign load_cycle_s = byte_state_s && !loaded_q && !abort;

  // Packet sequencing state, byte-load flag, captured header and payload countdown.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      loaded_q    <= 1'b0;
      remaining_q <= '0;
      len_q       <= '0;
      pid_q       <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          loaded_q <= 1'b0;
          if (start_ok_s) begin
            pid_q       <= pid;
            len_q       <= length;
            remaining_q <= length;
            state_q     <= ST_SYNC;
          end
        end
        ST_EOP: begin
          loaded_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
        ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
          if (abort) begin
            loaded_q <= 1'b0;
            state_q  <= ST_EOP;
          end else if (!loaded_q) begin
            if ((state_q == ST_DATA) && fifo_empty) begin
              state_q <= ST_EOP;
            end else begin
              loaded_q <= 1'b1;
              if (state_q == ST_DATA) begin
                remaining_q <= remaining_q - LEN_W'(1);
              end
            end
          end else if (byte_done && !tx_hold) begin
            loaded_q <= 1'b0;
            case (state_q)
              ST_SYNC:   state_q <= ST_PID;
              ST_PID:    state_q <= (len_q != '0) ? ST_DATA : POST_DATA;
              ST_DATA:   state_q <= (remaining_q == '0) ? POST_DATA : ST_DATA;
              ST_CRC_LO: state_q <= ST_CRC_HI;
              ST_CRC_HI: state_q <= ST_EOP;
              default:   state_q <= ST_EOP;
            endcase
          end
        end
        default: begin
          loaded_q <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; input-qualified pulses are held off during reset.
  always_comb begin
    fifo_read  = 1'b0;
    crc_clear  = 1'b0;
    crc_update = 1'b0;
    shift_load = 1'b0;
    shift_data = 8'h00;
    create_eop = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    underrun   = 1'b0;
    len_err    = 1'b0;
    if (n_rst) begin
      case (state_q)
        ST_IDLE: begin
          crc_clear = start_ok_s;
          len_err   = len_bad_s;
        end
        ST_SYNC: begin
          busy       = 1'b1;
          shift_data = 8'h80;
          shift_load = load_cycle_s;
        end
        ST_PID: begin
          busy       = 1'b1;
          shift_data = pid_q;
          shift_load = load_cycle_s;
        end
        ST_DATA: begin
          busy       = 1'b1;
          shift_data = fifo_rdata;
          if (load_cycle_s && !fifo_empty) begin
            fifo_read  = 1'b1;
            crc_update = 1'b1;
            shift_load = 1'b1;
          end else if (load_cycle_s) begin
            underrun = 1'b1;
          end else begin
            shift_load = 1'b0;
          end
        end
        ST_CRC_LO: begin
          busy       = 1'b1;
          shift_data = crc_in[7:0];
          shift_load = load_cycle_s;
        end
        ST_CRC_HI: begin
          busy       = 1'b1;
          shift_data = crc_in[15:8];
          shift_load = load_cycle_s;
        end
        ST_EOP: begin
          busy       = 1'b1;
          create_eop = 1'b1;
          done       = 1'b1;
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_pkt_seq.sv
// Directed bench for usb_tx_pkt_seq: FIFO/shifter stand-ins plus hand-computed expectations.
module tb_usb_tx_pkt_seq;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start;
  logic [7:0]       pid;
  logic [LEN_W-1:0] length;
  logic             abort;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             fifo_read;
  logic [15:0]      crc_in;
  logic             crc_clear;
  logic             crc_update;
  logic             shift_load;
  logic [7:0]       shift_data;
  logic             byte_done;
  logic             tx_hold;
  logic             create_eop;
  logic             busy;
  logic             done;
  logic             underrun;
  logic             len_err;

  logic [7:0] mem [0:255];
  logic [7:0] log_mem [0:511];
  int wr_cnt = 0;
  int rd_ptr = 0;
  int log_n = 0;
  int n_reads = 0;
  int n_upd = 0;
  int n_chk = 0;
  int n_fail = 0;

  usb_tx_pkt_seq #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CRC_BYTES(2)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .pid(pid), .length(length), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_read(fifo_read), .crc_in(crc_in),
    .crc_clear(crc_clear), .crc_update(crc_update), .shift_load(shift_load),
    .shift_data(shift_data), .byte_done(byte_done), .tx_hold(tx_hold),
    .create_eop(create_eop), .busy(busy), .done(done), .underrun(underrun), .len_err(len_err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr >= wr_cnt);
  assign fifo_rdata = mem[rd_ptr[7:0]];

  // FIFO pop, pulse counters and a log of every byte handed to the shifter.
  always @(posedge clk) begin
    if (fifo_read) begin
      rd_ptr  <= rd_ptr + 1;
      n_reads <= n_reads + 1;
    end
    if (crc_update) n_upd <= n_upd + 1;
    if (shift_load) begin
      log_mem[log_n[8:0]] <= shift_data;
      log_n <= log_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[7:0]] = b;
    wr_cnt++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_load(input string tag, input logic [7:0] b, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (shift_load && (shift_data == b)) break;
      tick();
    end
    chk(tag, {23'd0, shift_load, shift_data}, {23'd0, 1'b1, b});
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [7:0] exp);
    chk(tag, {24'd0, log_mem[idx[8:0]]}, {24'd0, exp});
  endtask

  function automatic logic [8:0] pulses();
    return {fifo_read, crc_clear, crc_update, shift_load, create_eop, busy, done, underrun, len_err};
  endfunction

  int base_log;
  int base_rd;
  int base_upd;
  logic [7:0] exp_b;

  initial begin
    n_rst = 1'b0; start = 1'b0; pid = 8'h00; length = '0; abort = 1'b0;
    crc_in = 16'h1234; byte_done = 1'b1; tx_hold = 1'b0;
    #2;
    chk("reset_pulses", {23'd0, pulses()}, 32'd0);
    chk("reset_shift_data", {24'd0, shift_data}, 32'h00);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Three-byte packet with CRC.
    push(8'hA1); push(8'hB2); push(8'hC3);
    base_log = log_n; base_rd = n_reads; base_upd = n_upd;
    pid = 8'hC3; length = 7'd3; start = 1'b1;
    #1;
    chk("t1_crc_clear", {31'd0, crc_clear}, 32'd1);
    chk("t1_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    #1;
    chk("t1_sync_load", {22'd0, busy, shift_load, shift_data}, {22'd0, 1'b1, 1'b1, 8'h80});
    wait_done("t1_done", 40);
    chk("t1_eop", {31'd0, create_eop}, 32'd1);
    tick();
    chk("t1_after_eop", {30'd0, busy, done}, 32'd0);
    chk("t1_nbytes", log_n - base_log, 32'd7);
    chk_log("t1_b0", base_log + 0, 8'h80);
    chk_log("t1_b1", base_log + 1, 8'hC3);
    chk_log("t1_b2", base_log + 2, 8'hA1);
    chk_log("t1_b3", base_log + 3, 8'hB2);
    chk_log("t1_b4", base_log + 4, 8'hC3);
    chk_log("t1_b5", base_log + 5, 8'h34);
    chk_log("t1_b6", base_log + 6, 8'h12);
    chk("t1_reads", n_reads - base_rd, 32'd3);
    chk("t1_updates", n_upd - base_upd, 32'd3);

    // Zero-length packet: header and CRC only.
    base_log = log_n; base_rd = n_reads;
    pid = 8'h5A; length = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2_done", 40);
    chk("t2_eop", {31'd0, create_eop}, 32'd1);
    tick();
    chk("t2_nbytes", log_n - base_log, 32'd4);
    chk_log("t2_b0", base_log + 0, 8'h80);
    chk_log("t2_b1", base_log + 1, 8'h5A);
    chk_log("t2_b2", base_log + 2, 8'h34);
    chk_log("t2_b3", base_log + 3, 8'h12);
    chk("t2_reads", n_reads - base_rd, 32'd0);

    // FIFO runs dry before the second payload byte.
    push(8'h5E);
    base_rd = n_reads;
    pid = 8'h69; length = 7'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (underrun) break;
      tick();
    end
    chk("t3_underrun", {31'd0, underrun}, 32'd1);
    chk("t3_no_load", {30'd0, fifo_read, shift_load}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t3_eop", {30'd0, create_eop, done}, 32'd3);
    chk("t3_underrun_off", {31'd0, underrun}, 32'd0);
    tick();
    chk("t3_idle", {31'd0, busy}, 32'd0);
    chk("t3_reads", n_reads - base_rd, 32'd1);

    // Over-length request is rejected; maximum length then runs to completion.
    length = 7'd65; pid = 8'hE1; start = 1'b1;
    #1;
    chk("t4_len_err", {31'd0, len_err}, 32'd1);
    chk("t4_rej_quiet", {23'd0, pulses()}, 32'd1);
    tick();
    start = 1'b0;
    #1;
    chk("t4_still_idle", {30'd0, busy, len_err}, 32'd0);
    for (int i = 0; i < MAX_LEN; i++) push(8'((i * 7) + 3));
    base_log = log_n; base_rd = n_reads; base_upd = n_upd;
    length = 7'd64; start = 1'b1;
    #1;
    chk("t4_accept", {30'd0, crc_clear, len_err}, 32'd2);
    tick();
    start = 1'b0;
    wait_done("t4_done", 400);
    tick();
    chk("t4_reads", n_reads - base_rd, 32'd64);
    chk("t4_updates", n_upd - base_upd, 32'd64);
    chk("t4_nbytes", log_n - base_log, 32'd68);
    chk_log("t4_first", base_log + 2, 8'h03);
    exp_b = 8'((63 * 7) + 3);
    chk_log("t4_last", base_log + 65, exp_b);

    // tx_hold stalls PID despite byte_done; abort in DATA ends the packet.
    push(8'h4D);
    base_rd = n_reads;
    pid = 8'h96; length = 7'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_load("t5_pid_load", 8'h96, 20);
    tx_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t5_hold_pid", {24'd0, shift_data}, 32'h96);
      chk("t5_hold_noload", {30'd0, shift_load, fifo_read}, 32'd0);
    end
    tx_hold = 1'b0;
    tick();
    chk("t5_data_load", {22'd0, fifo_read, shift_load, shift_data}, {22'd0, 1'b1, 1'b1, 8'h4D});
    tick();
    abort = 1'b1;
    #1;
    chk("t5_abort_cycle", {30'd0, create_eop, busy}, 32'd1);
    tick();
    abort = 1'b0;
    chk("t5_abort_eop", {30'd0, create_eop, done}, 32'd3);
    tick();
    chk("t5_idle", {31'd0, busy}, 32'd0);
    chk("t5_reads", n_reads - base_rd, 32'd1);

    // Reset during CRC_LO drops the packet; a start right after release is taken.
    pid = 8'h77; length = 7'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_load("t6_crc_lo", 8'h34, 20);
    n_rst = 1'b0; start = 1'b1;
    #1;
    chk("t6_rst_pulses", {23'd0, pulses()}, 32'd0);
    chk("t6_rst_data", {24'd0, shift_data}, 32'h00);
    tick();
    chk("t6_rst_hold", {23'd0, pulses()}, 32'd0);
    n_rst = 1'b1;
    #1;
    chk("t6_restart", {30'd0, crc_clear, busy}, 32'd2);
    tick();
    start = 1'b0;
    #1;
    chk("t6_sync", {22'd0, busy, shift_load, shift_data}, {22'd0, 1'b1, 1'b1, 8'h80});
    wait_done("t6_done", 40);
    tick();
    chk("t6_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/usb_tx_pkt_seq.md
USB_TX_PKT_SEQ -- requirements
Module: usb_tx_pkt_seq

Interface
- REQ-001 SHALL have parameter MAX_LEN, default 64, meaning maximum payload bytes per packet.
- REQ-002 SHALL have parameter LEN_W, default 7, meaning length field width, sized to hold values 0..MAX_LEN.
- REQ-003 SHALL have parameter CRC_BYTES, default 2, meaning CRC bytes appended after payload; legal values are 0 and 2.
- REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge triggered.
- REQ-005 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
- REQ-006 SHALL have port start, input, 1 bit: request to send one packet; sampled only in IDLE.
- REQ-007 SHALL have port pid, input, 8 bits: PID byte, captured on accepted start.
- REQ-008 SHALL have port length, input, LEN_W bits: payload byte count, captured on accepted start.
- REQ-009 SHALL have port abort, input, 1 bit: terminate the current packet.
- REQ-010 SHALL have port fifo_empty, input, 1 bit: transmit FIFO empty.
- REQ-011 SHALL have port fifo_rdata, input, 8 bits: FIFO head byte (first-word fall-through).
- REQ-012 SHALL have port fifo_read, output, 1 bit: pop one FIFO byte.
- REQ-013 SHALL have port crc_in, input, 16 bits: final CRC16 value from the external CRC unit.
- REQ-014 SHALL have port crc_clear, output, 1 bit: reset the external CRC unit.
- REQ-015 SHALL have port crc_update, output, 1 bit: feed shift_data into the CRC unit.
- REQ-016 SHALL have port shift_load, output, 1 bit: load shift_data into the bit shifter.
- REQ-017 SHALL have port shift_data, output, 8 bits: byte to transmit.
- REQ-018 SHALL have port byte_done, input, 1 bit: shifter finished the current byte.
- REQ-019 SHALL have port tx_hold, input, 1 bit: bit-stuff stall; byte_done is ignored while tx_hold is high.
- REQ-020 SHALL have port create_eop, output, 1 bit: drive EOP.
- REQ-021 SHALL have port busy, output, 1 bit: packet in progress.
- REQ-022 SHALL have port done, output, 1 bit: packet complete pulse.
- REQ-023 SHALL have port underrun, output, 1 bit: FIFO ran dry mid-payload, pulse.
- REQ-024 SHALL have port len_err, output, 1 bit: start rejected because length exceeded MAX_LEN, pulse.

Function
- REQ-025 SHALL implement states IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP.
- REQ-026 SHALL accept start in IDLE when length<=MAX_LEN: capture pid and length, pulse crc_clear that cycle, and enter SYNC on the next edge.
- REQ-027 SHALL, on start in IDLE with length>MAX_LEN, stay in IDLE, pulse len_err for 1 cycle, and emit no other output activity.
- REQ-028 SHALL pulse shift_load for exactly one cycle, on the first cycle in each byte state (SYNC, PID, DATA, CRC_LO, CRC_HI), using an internal loaded flag.
- REQ-029 SHALL set shift_data to 8'h80 in SYNC, pid in PID, fifo_rdata in DATA, crc_in[7:0] in CRC_LO, and crc_in[15:8] in CRC_HI.
- REQ-030 SHALL advance from a byte state only on byte_done=1 with tx_hold=0, after the load cycle; byte_done during the load cycle is ignored.
- REQ-031 SHALL transition SYNC->PID.
- REQ-032 SHALL transition PID->DATA if length!=0; else PID->CRC_LO if CRC_BYTES=2; else PID->EOP.
- REQ-033 SHALL, in the DATA load cycle with fifo_empty=0, assert fifo_read, crc_update and shift_load together, and decrement the remaining count.
- REQ-034 SHALL, when the remaining count is 0 after byte_done, transition DATA->CRC_LO if CRC_BYTES=2, else DATA->EOP; otherwise DATA->DATA (reload).
- REQ-035 SHALL, in the DATA load cycle with fifo_empty=1, assert no load, pulse underrun, and go to EOP.
- REQ-036 SHALL transition CRC_LO->CRC_HI->EOP.
- REQ-037 SHALL, in EOP, assert create_eop and done for 1 cycle, then return to IDLE.
- REQ-038 SHALL, on abort=1 in any state other than IDLE or EOP, go to EOP on the next edge; abort has priority over all other transitions, and done is still pulsed.
- REQ-039 SHALL assert busy in every state except IDLE; start while busy is ignored.
- REQ-040 SHALL deassert all pulse outputs whenever their conditions are not met.

Reset
- REQ-041 SHALL, while n_rst=0, force state IDLE, loaded flag 0, remaining count 0, captured pid/length 0, and all outputs 0 (shift_data 8'h00).
- REQ-042 SHALL, on reset asserted mid-packet, abandon the packet immediately without create_eop; the first post-reset cycle is IDLE.

Verification
- REQ-043 SHALL cover: pid=8'hC3, length=3, FIFO holds A1,B2,C3, crc_in=16'h1234 -> shift_data sequence 80,C3,A1,B2,C3,34,12; 3 fifo_read pulses; 3 crc_update pulses; then create_eop and done.
- REQ-044 SHALL cover: length=0 with CRC_BYTES=2 -> bytes 80, pid, lo, hi, then EOP; no fifo_read.
- REQ-045 SHALL cover: fifo_empty=1 asserted before the second DATA load with length=4 -> exactly 1 fifo_read, underrun pulse, create_eop on the next cycle.
- REQ-046 SHALL cover: length=MAX_LEN+1 -> len_err pulse, busy stays 0; then length=MAX_LEN completes normally with MAX_LEN reads.
- REQ-047 SHALL cover: tx_hold=1 held for 5 cycles with byte_done=1 in PID -> no advance until tx_hold=0; abort in DATA -> EOP next cycle with done.
- REQ-048 SHALL cover: n_rst pulsed low in CRC_LO -> all outputs 0, busy 0, and a new start is accepted right after release.
